// File: rtl/dram_pkg.sv
// Shared geometry, block types and FSM states for the DRAM block responder.
// Geometry defaults come from the project config macros when they are defined.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

package dram_pkg;

    localparam int DRAM_ADDR_W       = `DRAM_ADDRESS_SIZE;
    localparam int DRAM_WORD_W       = `DRAM_WORD_SIZE;
    localparam int DRAM_BLOCK_WORDS  = `DRAM_BLOCK_SIZE;
    localparam int DRAM_DEPTH_BLOCKS = 1024;

    // Ceiling log2; log2(1) is 0.
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DRAM_OFFSET_W  = log2(DRAM_BLOCK_WORDS) + log2(DRAM_WORD_W / 8);
    localparam int DRAM_INDEX_W   = log2(DRAM_DEPTH_BLOCKS);
    localparam int DRAM_INDEX_LSB = DRAM_OFFSET_W;
    localparam int DRAM_INDEX_MSB = DRAM_INDEX_LSB + DRAM_INDEX_W - 1;

    typedef logic [DRAM_WORD_W-1:0] word_t;
    typedef word_t [DRAM_BLOCK_WORDS-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

endpackage

// File: rtl/dram_block_array.sv
// Single-port block storage: synchronous write, registered read.
// The read register is cleared by reset; the stored blocks are not.
module dram_block_array
   import dram_pkg::*;
#(
   parameter int    BLOCK_W      = DRAM_WORD_W * DRAM_BLOCK_WORDS,
   parameter int    DEPTH_BLOCKS = DRAM_DEPTH_BLOCKS,
   parameter int    INDEX_W      = log2(DEPTH_BLOCKS),
   parameter string INIT_FILE    = ""
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [INDEX_W-1:0] index,
   input  logic [BLOCK_W-1:0] wdata,
   output logic [BLOCK_W-1:0] rdata
);

   logic [BLOCK_W-1:0] storage [DEPTH_BLOCKS];

   // The array starts with all-zero contents at time 0.
   initial begin
      for (int i = 0; i < DEPTH_BLOCKS; i++) begin
         storage[i] = '0;
      end
   end

   // Commit the write block on the clock edge when the write enable is high.
   always_ff @(posedge clock) begin
      if (we) begin
         storage[index] <= wdata;
      end
   end

   // Registered read port; only the output register is cleared by reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= storage[index];
      end
   end

endmodule

// File: rtl/dram_block_responder.sv
// Main-memory model behind the dcache: latches one block request per mem_valid
// pulse and answers it with a single mem_ready pulse LATENCY cycles later.
module dram_block_responder
    import dram_pkg::*;
#(
    parameter int    ADDR_W       = DRAM_ADDR_W,
    parameter int    WORD_W       = DRAM_WORD_W,
    parameter int    BLOCK_WORDS  = DRAM_BLOCK_WORDS,
    parameter int    DEPTH_BLOCKS = DRAM_DEPTH_BLOCKS,
    parameter int    LATENCY      = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_data_in [BLOCK_WORDS],
    input  logic              mem_rw,
    input  logic              mem_valid,
    output logic [WORD_W-1:0] mem_data_out [BLOCK_WORDS],
    output logic              mem_ready,
    output logic              busy,
    output logic              protocol_err
);

    localparam int OFFSET_W = log2(BLOCK_WORDS) + log2(WORD_W / 8);
    localparam int INDEX_W  = log2(DEPTH_BLOCKS);
    localparam int BLOCK_W  = WORD_W * BLOCK_WORDS;
    localparam int CNT_W    = (LATENCY > 1) ? log2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic [INDEX_W-1:0] req_index;
    logic               req_rw;
    logic [BLOCK_W-1:0] req_data;
    logic [BLOCK_W-1:0] data_in_flat;
    logic [BLOCK_W-1:0] rdata;
    logic               accept;
    logic               commit;
    logic               array_we;
    logic               array_re;
    logic               unused_addr_bits;

    // Bits outside the block index alias or select within a block; both are ignored.
    assign unused_addr_bits = ^{mem_address[ADDR_W-1:OFFSET_W+INDEX_W],
                                mem_address[OFFSET_W-1:0]};

    for (genvar w = 0; w < BLOCK_WORDS; w++) begin : g_words
        assign data_in_flat[w*WORD_W +: WORD_W] = mem_data_in[w];
        assign mem_data_out[w]                  = rdata[w*WORD_W +: WORD_W];
    end

    assign accept = mem_valid && (state == IDLE || state == RESPOND);
    assign commit = (state == WAIT) && (count == '0);

    // Storage is touched only on the edge entering RESPOND, never under reset.
    assign array_we = reset && commit && req_rw;
    assign array_re = reset && commit && !req_rw;

    // Every request passes through WAIT; with LATENCY==1 that stay is one cycle
    // with the counter already at zero, keeping valid-to-ready at LATENCY edges.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mem_valid) next_state = WAIT;
            WAIT:    if (count == '0) next_state = RESPOND;
            RESPOND: next_state = mem_valid ? WAIT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                count <= CNT_LOAD;
            end else if (state == WAIT && count != '0) begin
                count <= count - 1'b1;
            end
            if (state == WAIT && mem_valid) begin
                protocol_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            req_index <= mem_address[OFFSET_W +: INDEX_W];
            req_rw    <= mem_rw;
            req_data  <= data_in_flat;
        end
    end

    assign mem_ready = (state == RESPOND);
    assign busy      = (state != IDLE);

    dram_block_array #(
        .BLOCK_W      (BLOCK_W),
        .DEPTH_BLOCKS (DEPTH_BLOCKS),
        .INDEX_W      (INDEX_W),
        .INIT_FILE    (INIT_FILE)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (array_we),
        .re    (array_re),
        .index (req_index),
        .wdata (req_data),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dram_block_responder.sv
// Directed bench for dram_block_responder: a LATENCY=4 instance for the main
// protocol cases and a LATENCY=1 instance for back-to-back reads.
module tb_dram_block_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in [4];
    logic        mem_rw;
    logic        mem_valid;
    logic [31:0] mem_data_out [4];
    logic        mem_ready;
    logic        busy;
    logic        protocol_err;

    logic [31:0] mem_address_1;
    logic [31:0] mem_data_in_1 [4];
    logic        mem_rw_1;
    logic        mem_valid_1;
    logic [31:0] mem_data_out_1 [4];
    logic        mem_ready_1;
    logic        busy_1;
    logic        protocol_err_1;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] BLK_A    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    localparam logic [127:0] BLK_B    = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    localparam logic [127:0] BLK_C    = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    localparam logic [127:0] BLK_D    = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    localparam logic [127:0] BLK_E    = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
    localparam logic [127:0] BLK_DEAD = {4{32'hDEAD_BEEF}};

    always #5 clock = ~clock;

    dram_block_responder #(.LATENCY(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_rw       (mem_rw),
        .mem_valid    (mem_valid),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    dram_block_responder #(.LATENCY(1)) dut_l1 (
        .clock        (clock),
        .reset        (reset),
        .mem_address  (mem_address_1),
        .mem_data_in  (mem_data_in_1),
        .mem_rw       (mem_rw_1),
        .mem_valid    (mem_valid_1),
        .mem_data_out (mem_data_out_1),
        .mem_ready    (mem_ready_1),
        .busy         (busy_1),
        .protocol_err (protocol_err_1)
    );

    function automatic logic [127:0] flat(input logic [31:0] b [4]);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [127:0] l1_blk(input int i);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = 32'h1100_0000 + 32'(i * 16 + w);
        end
        return b;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    // Drives one request for exactly one cycle, then scrambles the inputs.
    task automatic applyStimulus(input logic [31:0] addr, input logic rw, input logic [127:0] data);
        mem_address = addr;
        mem_rw      = rw;
        for (int w = 0; w < 4; w++) mem_data_in[w] = data[w*32 +: 32];
        mem_valid = 1'b1;
        tick;
        mem_valid   = 1'b0;
        mem_address = ~addr;
        mem_rw      = ~rw;
        for (int w = 0; w < 4; w++) mem_data_in[w] = ~data[w*32 +: 32];
    endtask

    task automatic wait_ready(input string tag, input int exp_lat);
        int lat;
        bit busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        while (mem_ready !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick;
            lat++;
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        checkOutput({tag, "_busy"}, 128'(busy_ok && (busy === 1'b1)), 128'(1));
    endtask

    task automatic expect_idle(input string tag);
        tick;
        checkOutput({tag, "_ready_drop"}, 128'(mem_ready), 128'(0));
        checkOutput({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick;
            if (mem_ready !== 1'b0) seen = 1'b1;
        end
        checkOutput({tag, "_no_ready"}, 128'(seen), 128'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        mem_valid     = 1'b0;
        mem_rw        = 1'b0;
        mem_address   = '0;
        mem_valid_1   = 1'b0;
        mem_rw_1      = 1'b0;
        mem_address_1 = '0;
        for (int w = 0; w < 4; w++) begin
            mem_data_in[w]   = '0;
            mem_data_in_1[w] = '0;
        end
        tick;
        tick;
        reset = 1'b1;

        checkOutput("rst_ready", 128'(mem_ready), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_perr", 128'(protocol_err), 128'(0));
        checkOutput("rst_data", flat(mem_data_out), 128'(0));
        checkOutput("rst_l1_busy", 128'(busy_1), 128'(0));

        $display("[TB] fresh read");
        applyStimulus(32'h0000_0040, 1'b0, 128'(0));
        wait_ready("rd_fresh", 4);
        checkOutput("rd_fresh_data", flat(mem_data_out), 128'(0));
        expect_idle("rd_fresh");

        $display("[TB] write then offset and aliased reads");
        applyStimulus(32'h0000_0040, 1'b1, BLK_A);
        wait_ready("wr_a", 4);
        checkOutput("wr_a_keeps_out", flat(mem_data_out), 128'(0));
        expect_idle("wr_a");
        applyStimulus(32'h0000_004C, 1'b0, 128'(0));
        wait_ready("rd_4c", 4);
        checkOutput("rd_4c_data", flat(mem_data_out), BLK_A);
        expect_idle("rd_4c");
        applyStimulus(32'h0004_0040, 1'b0, 128'(0));
        wait_ready("rd_alias", 4);
        checkOutput("rd_alias_data", flat(mem_data_out), BLK_A);
        expect_idle("rd_alias");

        $display("[TB] write-back then refill");
        applyStimulus(32'h0000_0200, 1'b1, BLK_C);
        wait_ready("wr_c", 4);
        checkOutput("wr_c_keeps_out", flat(mem_data_out), BLK_A);
        expect_idle("wr_c");
        applyStimulus(32'h0000_0100, 1'b1, BLK_B);
        wait_ready("wb", 4);
        applyStimulus(32'h0000_0200, 1'b0, 128'(0));
        wait_ready("refill", 4);
        checkOutput("refill_data", flat(mem_data_out), BLK_C);
        checkOutput("refill_perr", 128'(protocol_err), 128'(0));
        expect_idle("refill");
        applyStimulus(32'h0000_0100, 1'b1, BLK_D);
        wait_ready("wr_d", 4);
        applyStimulus(32'h0000_0100, 1'b0, 128'(0));
        wait_ready("raw", 4);
        checkOutput("raw_data", flat(mem_data_out), BLK_D);
        expect_idle("raw");

        $display("[TB] request during wait");
        applyStimulus(32'h0000_0040, 1'b0, 128'(0));
        tick;
        mem_valid   = 1'b1;
        mem_rw      = 1'b0;
        mem_address = 32'h0000_0200;
        tick;
        mem_valid = 1'b0;
        checkOutput("perr_set", 128'(protocol_err), 128'(1));
        wait_ready("perr_orig", 2);
        checkOutput("perr_orig_data", flat(mem_data_out), BLK_A);
        expect_idle("perr");
        expect_silence("perr_drop", 8);
        checkOutput("perr_sticky", 128'(protocol_err), 128'(1));
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checkOutput("perr_cleared", 128'(protocol_err), 128'(0));
        checkOutput("rst_clears_out", flat(mem_data_out), 128'(0));

        $display("[TB] reset during write");
        applyStimulus(32'h0000_0300, 1'b1, BLK_E);
        wait_ready("wr_e", 4);
        expect_idle("wr_e");
        applyStimulus(32'h0000_0300, 1'b1, BLK_DEAD);
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checkOutput("rst_mid_busy", 128'(busy), 128'(0));
        expect_silence("rst_mid", 8);
        applyStimulus(32'h0000_0300, 1'b0, 128'(0));
        wait_ready("rd_old", 4);
        checkOutput("rd_old_data", flat(mem_data_out), BLK_E);
        expect_idle("rd_old");

        $display("[TB] latency-1 back-to-back");
        for (int j = 0; j < 8; j++) begin
            mem_address_1 = 32'((j % 4) * 16);
            mem_rw_1      = (j < 4);
            for (int w = 0; w < 4; w++) mem_data_in_1[w] = l1_blk(j % 4) >> (w * 32);
            mem_valid_1 = 1'b1;
            tick;
            mem_valid_1 = 1'b0;
            for (int w = 0; w < 4; w++) mem_data_in_1[w] = 32'hFFFF_FFFF;
            checkOutput($sformatf("l1_gap%0d", j), 128'(mem_ready_1), 128'(0));
            tick;
            checkOutput($sformatf("l1_ready%0d", j), 128'(mem_ready_1), 128'(1));
            if (j >= 4) begin
                checkOutput($sformatf("l1_data%0d", j), flat(mem_data_out_1), l1_blk(j - 4));
            end
        end
        tick;
        checkOutput("l1_ready_drop", 128'(mem_ready_1), 128'(0));
        checkOutput("l1_busy_drop", 128'(busy_1), 128'(0));
        checkOutput("l1_perr", 128'(protocol_err_1), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
